// File: rtl/i2s_rx_deser.sv
// ---------------------------------------------------------------------------
// i2s_rx_deser
//
// I2S receiver and deserializer. The asynchronous I2S bus (BCK, WS, DATA) is
// oversampled in the i_clk domain. MSB-justified left and right words are
// recovered and delivered as one parallel stereo pair per frame.
//
// Parameters:
//   SAMPLE_WIDTH  bits kept per channel, counted from the MSB
//   TIMEOUT       i_clk cycles without a BCK rising edge before lock drops
//
// Ports:
//   i_clk          system clock, at least 4x BCK
//   i_rst          synchronous active-high reset
//   i_bck          I2S bit clock (asynchronous)
//   i_ws           I2S word select, 0 = left, 1 = right (asynchronous)
//   i_data         I2S serial data, MSB first (asynchronous)
//   o_left         left sample of the last complete frame
//   o_right        right sample of the last complete frame
//   o_valid        one-cycle strobe, o_left/o_right are new in this cycle
//   o_err          one-cycle strobe, left/right word lengths differed
//   o_locked       high while the receiver FSM is in RUN (state visibility)
//   o_bits_per_ch  BCK count of the last completed right word, sat. at 63
//
// Output handshake: o_valid is a single-cycle strobe with no ready/back-
// pressure. The pair on o_left/o_right (and o_err) is meaningful only in the
// o_valid cycle, and the consumer must take it in that cycle.
// ---------------------------------------------------------------------------
module i2s_rx_deser #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_bck,
    input  logic                    i_ws,
    input  logic                    i_data,
    output logic [SAMPLE_WIDTH-1:0] o_left,
    output logic [SAMPLE_WIDTH-1:0] o_right,
    output logic                    o_valid,
    output logic                    o_err,
    output logic                    o_locked,
    output logic [5:0]              o_bits_per_ch
);

    localparam int            SW      = SAMPLE_WIDTH;
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [5:0]    CNT_MAX = 6'd63;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;

    // two-flop synchronizers plus the previous synced BCK
    logic            bck_s1_q, bck_s1_d, bck_s2_q, bck_s2_d, bck_d_q, bck_d_d;
    logic            ws_s1_q, ws_s1_d, ws_s2_q, ws_s2_d;
    logic            data_s1_q, data_s1_d, data_s2_q, data_s2_d;

    logic            ws_prev_q, ws_prev_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [SW-1:0]   left_hold_q, left_hold_d;
    logic [5:0]      left_len_q, left_len_d;
    logic            left_ok_q, left_ok_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    logic [SW-1:0]   left_out_q, left_out_d;
    logic [SW-1:0]   right_out_q, right_out_d;
    logic [5:0]      bits_q, bits_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic            rise;
    logic            boundary;
    logic            timeout;
    logic [5:0]      len;
    logic [SW-1:0]   word;

    always_comb begin
        bck_s1_d  = i_bck;
        bck_s2_d  = bck_s1_q;
        bck_d_d   = bck_s2_q;
        ws_s1_d   = i_ws;
        ws_s2_d   = ws_s1_q;
        data_s1_d = i_data;
        data_s2_d = data_s1_q;

        rise     = bck_s2_q & ~bck_d_q;
        boundary = rise & (ws_s2_q != ws_prev_q);
        // a rise in the same cycle as the terminal count keeps the lock
        timeout  = ~rise & (to_cnt_q == TO_LAST);
        len      = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 6'd1;

        // current word including this cycle's bit; positions past the
        // kept width match no index, so those bits are dropped
        word = sr_q;
        for (int i = 0; i < SW; i++) begin
            if (int'(cnt_q) == SW - 1 - i) begin
                word[i] = data_s2_q;
            end
        end

        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        left_hold_d = left_hold_q;
        left_len_d  = left_len_q;
        left_ok_d   = left_ok_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        bits_d      = bits_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        if (rise) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (rise) begin
            ws_prev_d = ws_s2_q;
            if (boundary) begin
                // next rise carries the MSB of the new word
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = word;
                cnt_d = len;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (boundary) begin
                    state_d   = ST_RUN;
                    left_ok_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (!ws_prev_q) begin
                        left_hold_d = word;
                        left_len_d  = len;
                        left_ok_d   = 1'b1;
                    end else begin
                        bits_d = len;
                        if (left_ok_q) begin
                            left_out_d  = left_hold_q;
                            right_out_d = word;
                            valid_d     = 1'b1;
                            err_d       = (len != left_len_q);
                            left_ok_d   = 1'b0;
                        end
                    end
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    left_ok_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            bck_s1_q    <= 1'b0;
            bck_s2_q    <= 1'b0;
            bck_d_q     <= 1'b0;
            ws_s1_q     <= 1'b0;
            ws_s2_q     <= 1'b0;
            data_s1_q   <= 1'b0;
            data_s2_q   <= 1'b0;
            ws_prev_q   <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            left_hold_q <= '0;
            left_len_q  <= '0;
            left_ok_q   <= 1'b0;
            to_cnt_q    <= '0;
            left_out_q  <= '0;
            right_out_q <= '0;
            bits_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bck_s1_q    <= bck_s1_d;
            bck_s2_q    <= bck_s2_d;
            bck_d_q     <= bck_d_d;
            ws_s1_q     <= ws_s1_d;
            ws_s2_q     <= ws_s2_d;
            data_s1_q   <= data_s1_d;
            data_s2_q   <= data_s2_d;
            ws_prev_q   <= ws_prev_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            left_hold_q <= left_hold_d;
            left_len_q  <= left_len_d;
            left_ok_q   <= left_ok_d;
            to_cnt_q    <= to_cnt_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            bits_q      <= bits_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign o_left        = left_out_q;
    assign o_right       = right_out_q;
    assign o_valid       = valid_q;
    assign o_err         = err_q;
    assign o_locked      = (state_q == ST_RUN);
    assign o_bits_per_ch = bits_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_deser
//
// Bench for i2s_rx_deser. Drives an I2S bus (WS switches together with the
// last bit of each word) and checks delivered frames against an expected
// queue built from a reference model of the word/frame rules.
// ---------------------------------------------------------------------------
module tb_i2s_rx_deser;

  localparam int SW      = 16;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          bck;
  logic          ws;
  logic          data;
  logic [SW-1:0] o_left;
  logic [SW-1:0] o_right;
  logic          o_valid;
  logic          o_err;
  logic          o_locked;
  logic [5:0]    o_bits_per_ch;

  i2s_rx_deser #(
    .SAMPLE_WIDTH(SW),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_bck        (bck),
    .i_ws         (ws),
    .i_data       (data),
    .o_left       (o_left),
    .o_right      (o_right),
    .o_valid      (o_valid),
    .o_err        (o_err),
    .o_locked     (o_locked),
    .o_bits_per_ch(o_bits_per_ch)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int last_rise_cyc = 0;

  // expected frame record: {err, bits_per_ch[5:0], left[15:0], right[15:0]}
  logic [38:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    bck  = 1'b0;
    ws   = 1'b0;
    data = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_o_left"},        o_left,        0);
    check({tag, "_o_right"},       o_right,       0);
    check({tag, "_o_valid"},       o_valid,       0);
    check({tag, "_o_err"},         o_err,         0);
    check({tag, "_o_locked"},      o_locked,      0);
    check({tag, "_o_bits_per_ch"}, o_bits_per_ch, 0);
  endtask

  // ---------------- reference model ----------------
  // v is the word MSB-justified in 64 bits; n bits are on the wire.
  function automatic logic [SW-1:0] ref_sample(input logic [63:0] v, input int n);
    logic [SW-1:0] s;
    s = v[63 -: SW];
    if (n < SW) s = s & ({SW{1'b1}} << (SW - n));
    return s;
  endfunction

  function automatic int ref_len(input int n);
    return (n > 63) ? 63 : n;
  endfunction

  function automatic logic [38:0] ref_frame(input int nl, input logic [63:0] lv,
                                            input int nr, input logic [63:0] rv);
    logic       e;
    logic [5:0] b;
    e = (ref_len(nl) != ref_len(nr));
    b = 6'(ref_len(nr));
    return {e, b, ref_sample(lv, nl), ref_sample(rv, nr)};
  endfunction

  // ---------------- driver ----------------
  // Bits [first, last) of an n-bit word; WS takes next_ch on the last bit.
  task automatic send_bits(input int n, input logic [63:0] v, input logic ch,
                           input logic next_ch, input int half, input int first,
                           input int last);
    for (int i = first; i < last; i++) begin
      bck  = 1'b0;
      data = (i < 64) ? v[63 - i] : 1'b0;
      ws   = (i == n - 1) ? next_ch : ch;
      repeat (half) @(negedge clk);
      bck = 1'b1;
      last_rise_cyc = cyc;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int nl, input logic [63:0] lv, input int nr,
                            input logic [63:0] rv, input int half, input bit expect_out);
    if (expect_out) exp_q.push_back(ref_frame(nl, lv, nr, rv));
    send_bits(nl, lv, 1'b0, 1'b1, half, 0, nl);
    send_bits(nr, rv, 1'b1, 1'b0, half, 0, nr);
  endtask

  task automatic drain(input string name);
    repeat (12) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", o_valid, 0);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        check("o_left",            o_left,        e[31:16]);
        check("o_right",           o_right,       e[15:0]);
        check("o_bits_per_ch",     o_bits_per_ch, e[37:32]);
        check("o_err",             o_err,         e[38]);
        check("o_locked_at_valid", o_locked,      1);
      end
    end else if (o_err === 1'b1) begin
      check("err_without_valid", o_err, 0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          do_rst;  // reset and send one discarded frame first
    int          nl;
    int          nr;
    logic [63:0] lv;
    logic [63:0] rv;
    int          half;
    int          reps;
    logic [15:0] el;
    logic [15:0] er;
    logic [5:0]  eb;
    logic        ee;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst  = 1'b1;
    bck  = 1'b0;
    ws   = 1'b0;
    data = 1'b0;

    vecs[0] = '{1'b1, 32, 32, 64'h1234_5A5A_0000_0000, 64'hABCD_0F0F_0000_0000, 3, 3,
                16'h1234, 16'hABCD, 6'd32, 1'b0};
    vecs[1] = '{1'b1, 16, 16, 64'h8001_0000_0000_0000, 64'h7FFE_0000_0000_0000, 2, 3,
                16'h8001, 16'h7FFE, 6'd16, 1'b0};
    vecs[2] = '{1'b1, 12, 12, 64'hABCF_FFFF_FFFF_FFFF, 64'h123F_FFFF_FFFF_FFFF, 3, 2,
                16'hABC0, 16'h1230, 6'd12, 1'b0};
    vecs[3] = '{1'b0, 32, 24, 64'h5A5A_1111_0000_0000, 64'hC3A5_96FF_FFFF_FFFF, 3, 1,
                16'h5A5A, 16'hC3A5, 6'd24, 1'b1};
    vecs[4] = '{1'b0, 32, 32, 64'h0F0F_3333_0000_0000, 64'hF0F0_CCCC_0000_0000, 4, 1,
                16'h0F0F, 16'hF0F0, 6'd32, 1'b0};
    vecs[5] = '{1'b1, 70, 70, 64'hDEAD_BEEF_0000_0001, 64'h6789_0000_FFFF_0000, 2, 2,
                16'hDEAD, 16'h6789, 6'd63, 1'b0};

    do_reset();
    @(negedge clk);
    check_all_zero("reset");

    // ---- table-driven frames ----
    for (int r = 0; r < 6; r++) begin
      if (vecs[r].do_rst) begin
        do_reset();
        send_frame(vecs[r].nl, vecs[r].lv, vecs[r].nr, vecs[r].rv, vecs[r].half, 1'b0);
      end
      for (int k = 0; k < vecs[r].reps; k++) begin
        exp_q.push_back({vecs[r].ee, vecs[r].eb, vecs[r].el, vecs[r].er});
        send_frame(vecs[r].nl, vecs[r].lv, vecs[r].nr, vecs[r].rv, vecs[r].half, 1'b0);
      end
      drain($sformatf("row%0d_all_delivered", r));
    end

    // ---- BCK stop: lock timeout ----
    begin
      int t0;
      int gap;
      do_reset();
      send_frame(16, 64'h1111_0000_0000_0000, 16, 64'h2222_0000_0000_0000, 2, 1'b0);
      send_frame(16, 64'h4321_0000_0000_0000, 16, 64'h8765_0000_0000_0000, 2, 1'b1);
      drain("pre_timeout_delivered");
      check("locked_before_stop", o_locked, 1);
      t0  = last_rise_cyc;
      gap = -1;
      for (int i = 0; i < 1100; i++) begin
        @(negedge clk);
        if (gap < 0 && o_locked !== 1'b1) gap = cyc - t0;
      end
      check_range("lock_drop_cycles", gap, TIMEOUT - 4, TIMEOUT + 10);
      check("timeout_outputs_held_left", o_left, 16'h4321);
      check("timeout_outputs_held_bits", o_bits_per_ch, 16);
      send_frame(16, 64'h0101_0000_0000_0000, 16, 64'h0202_0000_0000_0000, 2, 1'b0);
      send_frame(16, 64'hCAFE_0000_0000_0000, 16, 64'hF00D_0000_0000_0000, 2, 1'b1);
      drain("post_timeout_delivered");
      check("relocked", o_locked, 1);
    end

    // ---- reset in the middle of a right word ----
    do_reset();
    send_frame(24, 64'h1357_9B00_0000_0000, 24, 64'h2468_AC00_0000_0000, 3, 1'b0);
    send_frame(24, 64'h9ABC_DE00_0000_0000, 24, 64'h3456_7800_0000_0000, 3, 1'b1);
    send_bits(24, 64'h7777_7700_0000_0000, 1'b0, 1'b1, 3, 0, 24);
    send_bits(24, 64'h8888_8800_0000_0000, 1'b1, 1'b0, 3, 0, 10);
    check("pre_mid_reset_delivered", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");
    // The first rise after reset sees WS=1 against a cleared ws_prev and acts
    // as the locking boundary; the rest of the interrupted right word then
    // completes without a left word and is dropped.
    send_bits(24, 64'h8888_8800_0000_0000, 1'b1, 1'b0, 3, 10, 24);
    send_frame(24, 64'hBEEF_1200_0000_0000, 24, 64'hFACE_3400_0000_0000, 3, 1'b1);
    drain("post_mid_reset_delivered");

    // ---- randomized frames against the reference model ----
    begin
      int nd;
      do_reset();
      nd = $urandom_range(8, 40);
      send_frame(nd, {$urandom, $urandom}, nd, {$urandom, $urandom}, 2, 1'b0);
      repeat (12) @(negedge clk);
      check("dropped_right_updates_bits", o_bits_per_ch, 6'(nd));
      check("dropped_frame_locked", o_locked, 1);
      for (int k = 0; k < 24; k++) begin
        int nl;
        int nr;
        nl = $urandom_range(8, 40);
        nr = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : nl;
        send_frame(nl, {$urandom, $urandom}, nr, {$urandom, $urandom},
                   $urandom_range(2, 4), 1'b1);
      end
      drain("random_all_delivered");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (90000) @(posedge clk);
    total_cnt++;
    $display("FAIL watchdog: got %0d cycles, expected the run to end sooner", cyc);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
